// File: rtl/rcv_ctrl.sv
// rtl/rcv_ctrl.sv - UART receive control: start qualification, bit-centre strobes, stop check
//
// Ports:
//   clk            system clock, all state changes on the rising edge
//   n_rst          asynchronous active-low reset
//   serial_in      raw RX line (idles high), synchronized internally
//   stop_bit       captured stop bit (MSB of the external shift register)
//   shift_strobe   one-cycle pulse at each bit centre (shift enable)
//   load_buffer    one-cycle pulse when a frame with a good stop bit is captured
//   framing_error  sticky; set by a bad stop bit, cleared by the next valid start
//   rx_busy        high whenever the FSM is not idle
//
// Optional feature macro: RCV_GLITCH_REJECT_EN. When defined, the start bit is
// re-sampled at its centre and a line that has returned high aborts the frame.
// When undefined, START always proceeds to RECV after half a bit.

module rcv_ctrl #(
  parameter int CLKS_PER_BIT = 10,
  parameter int DATA_BITS    = 8
) (
  input  logic clk,
  input  logic n_rst,
  input  logic serial_in,
  input  logic stop_bit,
  output logic shift_strobe,
  output logic load_buffer,
  output logic framing_error,
  output logic rx_busy
);

  localparam int TW = $clog2(CLKS_PER_BIT);
  localparam int BW = $clog2(DATA_BITS + 2);

  // Timer value of the start-bit centre, and of each data-bit centre
  // (the RECV timer starts at the start-bit centre, so a full bit later
  // lands on the next bit centre).
  localparam logic [TW-1:0] T_HALF = TW'(CLKS_PER_BIT / 2 - 1);
  localparam logic [TW-1:0] T_LAST = TW'(CLKS_PER_BIT - 1);
  // Data bits plus the stop bit.
  localparam logic [BW-1:0] B_LAST = BW'(DATA_BITS + 1);

  typedef enum logic [2:0] {
    IDLE,
    START,
    RECV,
    STOP_CHK,
    LOAD
  } state_t;

  state_t          state, state_next;
  logic [TW-1:0]   timer, timer_next;
  logic [BW-1:0]   bit_cnt, bit_cnt_next;
  logic            fe_next;

  logic rx_meta, rx_sync, rx_prev;
  logic start_det;

  // Two-flop synchronizer plus one history flop for edge detection. All reset
  // high so that a reset never looks like a falling edge.
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      rx_meta <= 1'b1;
      rx_sync <= 1'b1;
      rx_prev <= 1'b1;
    end else begin
      rx_meta <= serial_in;
      rx_sync <= rx_meta;
      rx_prev <= rx_sync;
    end
  end

  assign start_det = rx_prev & ~rx_sync;

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      state         <= IDLE;
      timer         <= '0;
      bit_cnt       <= '0;
      framing_error <= 1'b0;
    end else begin
      state         <= state_next;
      timer         <= timer_next;
      bit_cnt       <= bit_cnt_next;
      framing_error <= fe_next;
    end
  end

  // Strobe and load pulses are decoded only from registered state and timer,
  // so they cannot glitch on the asynchronous-origin line or on stop_bit.
  always_comb begin
    state_next   = state;
    timer_next   = timer + TW'(1);
    bit_cnt_next = bit_cnt;
    fe_next      = framing_error;
    shift_strobe = 1'b0;
    load_buffer  = 1'b0;

    case (state)
      IDLE: begin
        timer_next = '0;
        if (start_det) begin
          state_next   = START;
          bit_cnt_next = '0;
        end
      end

      START: begin
        if (timer == T_HALF) begin
          timer_next = '0;
`ifdef RCV_GLITCH_REJECT_EN
          if (!rx_sync) begin
            state_next = RECV;
            fe_next    = 1'b0;
          end else begin
            state_next = IDLE;
          end
`else
          state_next = RECV;
          fe_next    = 1'b0;
`endif
        end
      end

      RECV: begin
        if (timer == T_LAST) begin
          timer_next   = '0;
          shift_strobe = 1'b1;
          bit_cnt_next = bit_cnt + BW'(1);
          if (bit_cnt + BW'(1) == B_LAST) begin
            state_next = STOP_CHK;
          end
        end
      end

      // One cycle after the final shift, so stop_bit reflects the stop bit.
      STOP_CHK: begin
        timer_next = '0;
        if (stop_bit) begin
          state_next = LOAD;
        end else begin
          state_next = IDLE;
          fe_next    = 1'b1;
        end
      end

      LOAD: begin
        timer_next  = '0;
        load_buffer = 1'b1;
        state_next  = IDLE;
      end

      default: begin
        timer_next = '0;
        state_next = IDLE;
      end
    endcase
  end

  assign rx_busy = (state != IDLE);

endmodule

// File: tb/tb_rcv_ctrl.sv
// tb/tb_rcv_ctrl.sv - self-checking bench for rcv_ctrl (default and 16/7 configurations)

module tb_rcv_ctrl;

  localparam int CPB_A = 10;
  localparam int DB_A  = 8;
  localparam int CPB_B = 16;
  localparam int DB_B  = 7;

  logic clk = 1'b0;
  logic n_rst = 1'b0;
  logic ser_a = 1'b1;
  logic ser_b = 1'b1;
  logic stop_a, stop_b;
  logic strb_a, load_a, fe_a, busy_a;
  logic strb_b, load_b, fe_b, busy_b;

  // Behavioural receive shift registers fed by the strobes (LSB first).
  logic [8:0] sr_a = '0;
  logic [7:0] sr_b = '0;

  int cyc = 0;
  int act = 0;
  int n_checks = 0;
  int n_errors = 0;
  bit fe_model = 1'b0;

  int obs_strb[$], obs_load[$], obs_data[$], obs_fe[$], obs_busy[$];
  int exp_strb[$], exp_load[$], exp_data[$], exp_fe[$], exp_busy[$];
  logic prev_fe = 1'b0;
  logic prev_busy = 1'b0;

  always #5 clk = ~clk;

  rcv_ctrl #(.CLKS_PER_BIT(CPB_A), .DATA_BITS(DB_A)) dut_a (
    .clk(clk), .n_rst(n_rst), .serial_in(ser_a), .stop_bit(stop_a),
    .shift_strobe(strb_a), .load_buffer(load_a), .framing_error(fe_a), .rx_busy(busy_a)
  );

  rcv_ctrl #(.CLKS_PER_BIT(CPB_B), .DATA_BITS(DB_B)) dut_b (
    .clk(clk), .n_rst(n_rst), .serial_in(ser_b), .stop_bit(stop_b),
    .shift_strobe(strb_b), .load_buffer(load_b), .framing_error(fe_b), .rx_busy(busy_b)
  );

  assign stop_a = sr_a[8];
  assign stop_b = sr_b[7];

  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (strb_a) sr_a <= {ser_a, sr_a[8:1]};
    if (strb_b) sr_b <= {ser_b, sr_b[7:1]};
  end

  // Event logger for the active instance; fe/busy are logged as 2*cycle+value.
  always @(negedge clk) begin : mon
    logic s, l, f, b;
    int d;
    if (act == 0) begin
      s = strb_a; l = load_a; f = fe_a; b = busy_a; d = int'(sr_a[7:0]);
    end else begin
      s = strb_b; l = load_b; f = fe_b; b = busy_b; d = int'(sr_b[6:0]);
    end
    if (s) obs_strb.push_back(cyc);
    if (l) begin
      obs_load.push_back(cyc);
      obs_data.push_back(d);
    end
    if (f !== prev_fe) obs_fe.push_back(cyc * 2 + int'(f));
    if (b !== prev_busy) obs_busy.push_back(cyc * 2 + int'(b));
    prev_fe = f;
    prev_busy = b;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d, expected %0d", tag, obs, exp);
    end
  endtask

  task automatic wait_cyc(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic set_line(input logic v);
    if (act == 0) ser_a = v;
    else ser_b = v;
  endtask

  task automatic clear_all();
    obs_strb.delete(); obs_load.delete(); obs_data.delete(); obs_fe.delete(); obs_busy.delete();
    exp_strb.delete(); exp_load.delete(); exp_data.delete(); exp_fe.delete(); exp_busy.delete();
  endtask

  // Reference model: given the cycle k at which the start edge is driven,
  // list every event the frame must produce.
  task automatic expect_frame(input int k, input int cpb, input int db,
                              input logic [7:0] data, input logic stop);
    int s, h, last;
    s = k + 3;
    h = cpb / 2;
    exp_busy.push_back(2 * s + 1);
    if (fe_model) exp_fe.push_back(2 * (s + h));
    fe_model = 1'b0;
    for (int j = 0; j <= db; j++) exp_strb.push_back(s + h + cpb - 1 + j * cpb);
    last = s + h + cpb - 1 + db * cpb;
    if (stop) begin
      exp_load.push_back(last + 2);
      exp_data.push_back(int'(data) & ((1 << db) - 1));
      exp_busy.push_back(2 * (last + 3));
    end else begin
      exp_fe.push_back(2 * (last + 2) + 1);
      fe_model = 1'b1;
      exp_busy.push_back(2 * (last + 2));
    end
  endtask

  task automatic send_frame(input int cpb, input int db, input logic [7:0] data, input logic stop);
    expect_frame(cyc, cpb, db, data, stop);
    set_line(1'b0);
    wait_cyc(cpb);
    for (int i = 0; i < db; i++) begin
      set_line(data[i]);
      wait_cyc(cpb);
    end
    set_line(stop);
    wait_cyc(cpb);
  endtask

  task automatic compare_all(input string sec);
    check({sec, " strobe count"}, obs_strb.size(), exp_strb.size());
    for (int i = 0; i < exp_strb.size() && i < obs_strb.size(); i++)
      check($sformatf("%s strobe[%0d] cycle", sec, i), obs_strb[i], exp_strb[i]);
    check({sec, " load count"}, obs_load.size(), exp_load.size());
    for (int i = 0; i < exp_load.size() && i < obs_load.size(); i++) begin
      check($sformatf("%s load[%0d] cycle", sec, i), obs_load[i], exp_load[i]);
      check($sformatf("%s load[%0d] data", sec, i), obs_data[i], exp_data[i]);
    end
    check({sec, " framing_error events"}, obs_fe.size(), exp_fe.size());
    for (int i = 0; i < exp_fe.size() && i < obs_fe.size(); i++)
      check($sformatf("%s framing_error[%0d] 2*cycle+val", sec, i), obs_fe[i], exp_fe[i]);
    check({sec, " rx_busy events"}, obs_busy.size(), exp_busy.size());
    for (int i = 0; i < exp_busy.size() && i < obs_busy.size(); i++)
      check($sformatf("%s rx_busy[%0d] 2*cycle+val", sec, i), obs_busy[i], exp_busy[i]);
  endtask

  task automatic run_stream(input string sec, input int cpb, input int db,
                            input int nfr, input bit directed);
    logic [7:0] d;
    logic st;
    int gap;
    clear_all();
    for (int f = 0; f < nfr; f++) begin
      d = 8'($urandom);
      st = ($urandom_range(0, 3) != 0);
      gap = ($urandom_range(0, 3) == 0) ? 0 : $urandom_range(1, 2 * cpb);
      if (directed) begin
        case (f)
          0: begin d = 8'hA5; st = 1'b1; gap = 0; end
          1: begin d = 8'h5A; st = 1'b1; gap = 5; end
          2: begin d = 8'h3C; st = 1'b0; gap = 7; end
          3: begin st = 1'b1; end
          default: ;
        endcase
      end
      if (!st && gap < 2) gap = 2;
      send_frame(cpb, db, d, st);
      set_line(1'b1);
      if (gap > 0) wait_cyc(gap);
    end
    wait_cyc(4 * cpb);
    compare_all(sec);
  endtask

  task automatic glitch_test();
    int k;
    clear_all();
    k = cyc;
    set_line(1'b0);
    wait_cyc(3);
    set_line(1'b1);
`ifdef RCV_GLITCH_REJECT_EN
    exp_busy.push_back(2 * (k + 3) + 1);
    exp_busy.push_back(2 * (k + 8));
`else
    expect_frame(k, CPB_A, DB_A, 8'hFF, 1'b1);
`endif
    wait_cyc(150);
    compare_all("glitch");
  endtask

  task automatic reset_mid_frame();
    clear_all();
    set_line(1'b0);
    wait_cyc(50);
    check("pre-reset strobe count", obs_strb.size(), 4);
    check("pre-reset rx_busy", busy_a, 1'b1);
    n_rst = 1'b0;
    #1;
    check("async reset shift_strobe", strb_a, 1'b0);
    check("async reset load_buffer", load_a, 1'b0);
    check("async reset framing_error", fe_a, 1'b0);
    check("async reset rx_busy", busy_a, 1'b0);
    set_line(1'b1);
    wait_cyc(3);
    n_rst = 1'b1;
    fe_model = 1'b0;
    clear_all();
    wait_cyc(150);
    compare_all("after reset");
  endtask

  initial begin
    wait_cyc(3);
    check("reset shift_strobe a", strb_a, 1'b0);
    check("reset load_buffer a", load_a, 1'b0);
    check("reset framing_error a", fe_a, 1'b0);
    check("reset rx_busy a", busy_a, 1'b0);
    check("reset shift_strobe b", strb_b, 1'b0);
    check("reset load_buffer b", load_b, 1'b0);
    check("reset framing_error b", fe_b, 1'b0);
    check("reset rx_busy b", busy_b, 1'b0);
    n_rst = 1'b1;
    wait_cyc(5);

    run_stream("stream10", CPB_A, DB_A, 12, 1'b1);
    glitch_test();
    reset_mid_frame();

    act = 1;
    wait_cyc(2);
    fe_model = 1'b0;
    run_stream("stream16", CPB_B, DB_B, 6, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
